// File: rtl/hardwired_control_seq.sv
// hardwired_control_seq: timing-step sequencer for a basic accumulator CPU.
// A sequence counter selects Tn. Decode of sc, IR and flags produces the
// combinational register strobes, bus select, ALU select and memory requests.
// A memory step stalls the counter until mem_ready. A register-reference HLT
// parks the sequencer until reset.
// Optional interrupt cycle (ION/IOF, R flag, RT0..RT2): define CU_INTERRUPT_EN.
module hardwired_control_seq #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned SC_W   = 4
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [DATA_W-1:0] ir_i,
  input  logic              mem_ready_i,
  input  logic              dr_zero_i,
  input  logic              irq_i,
  output logic [4:0]        ld_o,
  output logic [3:0]        inr_o,
  output logic [3:0]        clr_o,
  output logic              mem_rd_o,
  output logic              mem_wr_o,
  output logic [2:0]        bus_sel_o,
  output logic [1:0]        alu_op_o,
  output logic [SC_W-1:0]   sc_o,
  output logic              halted_o,
  output logic              ien_o
);

  localparam int unsigned LD_W  = 5;
  localparam int unsigned REG_W = 4;

  // Bit positions inside ld {AR,PC,DR,AC,IR}
  localparam int unsigned LD_AR = 4;
  localparam int unsigned LD_PC = 3;
  localparam int unsigned LD_DR = 2;
  localparam int unsigned LD_AC = 1;
  localparam int unsigned LD_IR = 0;

  // Bit positions inside inr/clr {AR,PC,DR,AC}
  localparam int unsigned R_AR = 3;
  localparam int unsigned R_PC = 2;
  localparam int unsigned R_DR = 1;
  localparam int unsigned R_AC = 0;

  localparam logic [2:0] BUS_NONE = 3'd0;
  localparam logic [2:0] BUS_AR   = 3'd1;
  localparam logic [2:0] BUS_PC   = 3'd2;
  localparam logic [2:0] BUS_DR   = 3'd3;
  localparam logic [2:0] BUS_AC   = 3'd4;
  localparam logic [2:0] BUS_IR   = 3'd5;
  localparam logic [2:0] BUS_MEM  = 3'd7;

  localparam logic [1:0] ALU_AND  = 2'd0;
  localparam logic [1:0] ALU_ADD  = 2'd1;
  localparam logic [1:0] ALU_PASS = 2'd2;

  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_LDA = 3'd2;
  localparam logic [2:0] OP_STA = 3'd3;
  localparam logic [2:0] OP_BUN = 3'd4;
  localparam logic [2:0] OP_BSA = 3'd5;
  localparam logic [2:0] OP_ISZ = 3'd6;
  localparam logic [2:0] OP_REG = 3'd7;

  localparam logic [SC_W-1:0] T0 = SC_W'(0);
  localparam logic [SC_W-1:0] T1 = SC_W'(1);
  localparam logic [SC_W-1:0] T2 = SC_W'(2);
  localparam logic [SC_W-1:0] T3 = SC_W'(3);
  localparam logic [SC_W-1:0] T4 = SC_W'(4);
  localparam logic [SC_W-1:0] T5 = SC_W'(5);
  localparam logic [SC_W-1:0] T6 = SC_W'(6);

  logic [SC_W-1:0] sc_q, sc_d;
  logic            halted_q, halted_d;

  logic             i_bit;
  logic [2:0]       opc;

  // Raw decode before stall gating
  logic [LD_W-1:0]  ld_c;
  logic [REG_W-1:0] inr_c;
  logic [REG_W-1:0] clr_c;
  logic             rd_c;
  logic             wr_c;
  logic [2:0]       bus_c;
  logic [1:0]       alu_c;
  logic             sc_clr_c;
  logic             halt_c;
  logic             adv_c;

`ifdef CU_INTERRUPT_EN
  logic ien_q, ien_d;
  logic r_q, r_d;
  logic rt_c;
  logic ion_c;
  logic iof_c;
  logic rt_done_c;
`endif

  // Inputs partly consumed only in some builds or at fixed bit positions
  logic unused_c;
  assign unused_c = ^{ir_i, irq_i};

  assign i_bit = ir_i[DATA_W-1];
  assign opc   = ir_i[DATA_W-2 -: 3];

`ifdef CU_INTERRUPT_EN
  // Interrupt cycle replaces the fetch steps while R is pending
  assign rt_c = r_q && (sc_q < T3);
`endif

  // Step decode: strobes and requests for the current timing step
  always_comb begin
    ld_c     = '0;
    inr_c    = '0;
    clr_c    = '0;
    rd_c     = 1'b0;
    wr_c     = 1'b0;
    bus_c    = BUS_NONE;
    alu_c    = ALU_AND;
    sc_clr_c = 1'b0;
    halt_c   = 1'b0;
`ifdef CU_INTERRUPT_EN
    ion_c     = 1'b0;
    iof_c     = 1'b0;
    rt_done_c = 1'b0;
`endif

    case (sc_q)
      T0: begin
        bus_c        = BUS_PC;
        ld_c[LD_AR]  = 1'b1;
      end
      T1: begin
        bus_c        = BUS_MEM;
        rd_c         = 1'b1;
        ld_c[LD_IR]  = 1'b1;
        inr_c[R_PC]  = 1'b1;
      end
      T2: begin
        bus_c        = BUS_IR;
        ld_c[LD_AR]  = 1'b1;
      end
      T3: begin
        if (opc == OP_REG) begin
          // Register reference (I=0) or unused I=1 slot: always ends here
          sc_clr_c = 1'b1;
          if (!i_bit) begin
            clr_c[R_AC] = ir_i[11];
            inr_c[R_AC] = ir_i[5];
            halt_c      = ir_i[0];
`ifdef CU_INTERRUPT_EN
            ion_c       = ir_i[7];
            iof_c       = ir_i[6];
`endif
          end
        end else if (i_bit) begin
          // Indirect: fetch effective address into AR
          bus_c       = BUS_MEM;
          rd_c        = 1'b1;
          ld_c[LD_AR] = 1'b1;
        end
      end
      T4: begin
        case (opc)
          OP_AND, OP_ADD, OP_LDA, OP_ISZ: begin
            bus_c       = BUS_MEM;
            rd_c        = 1'b1;
            ld_c[LD_DR] = 1'b1;
          end
          OP_STA: begin
            bus_c    = BUS_AC;
            wr_c     = 1'b1;
            sc_clr_c = 1'b1;
          end
          OP_BUN: begin
            bus_c       = BUS_AR;
            ld_c[LD_PC] = 1'b1;
            sc_clr_c    = 1'b1;
          end
          OP_BSA: begin
            bus_c        = BUS_PC;
            wr_c         = 1'b1;
            inr_c[R_AR]  = 1'b1;
          end
          default: ;
        endcase
      end
      T5: begin
        case (opc)
          OP_AND: begin
            ld_c[LD_AC] = 1'b1;
            alu_c       = ALU_AND;
            sc_clr_c    = 1'b1;
          end
          OP_ADD: begin
            ld_c[LD_AC] = 1'b1;
            alu_c       = ALU_ADD;
            sc_clr_c    = 1'b1;
          end
          OP_LDA: begin
            ld_c[LD_AC] = 1'b1;
            alu_c       = ALU_PASS;
            sc_clr_c    = 1'b1;
          end
          OP_BSA: begin
            bus_c       = BUS_AR;
            ld_c[LD_PC] = 1'b1;
            sc_clr_c    = 1'b1;
          end
          OP_ISZ: begin
            inr_c[R_DR] = 1'b1;
          end
          default: ;
        endcase
      end
      T6: begin
        if (opc == OP_ISZ) begin
          // Write back incremented DR; skip next instruction if it wrapped to zero
          bus_c       = BUS_DR;
          wr_c        = 1'b1;
          sc_clr_c    = 1'b1;
          inr_c[R_PC] = dr_zero_i;
        end
      end
      default: ;
    endcase

`ifdef CU_INTERRUPT_EN
    if (rt_c) begin
      ld_c     = '0;
      inr_c    = '0;
      clr_c    = '0;
      rd_c     = 1'b0;
      wr_c     = 1'b0;
      bus_c    = BUS_NONE;
      alu_c    = ALU_AND;
      sc_clr_c = 1'b0;
      halt_c   = 1'b0;
      ion_c    = 1'b0;
      iof_c    = 1'b0;
      case (sc_q)
        T0: clr_c[R_AR] = 1'b1;
        T1: begin
          bus_c       = BUS_PC;
          wr_c        = 1'b1;
          clr_c[R_PC] = 1'b1;
        end
        default: begin
          inr_c[R_PC] = 1'b1;
          rt_done_c   = 1'b1;
          sc_clr_c    = 1'b1;
        end
      endcase
    end
`endif
  end

  // A memory step completes only when memory is ready
  assign adv_c = !((rd_c || wr_c) && !mem_ready_i);

  // Next-state for counter and flags; nothing moves while stalled or halted
  always_comb begin
    sc_d     = sc_q;
    halted_d = halted_q;
`ifdef CU_INTERRUPT_EN
    ien_d    = ien_q;
    r_d      = r_q;
`endif
    if (!halted_q && adv_c) begin
      sc_d = sc_clr_c ? '0 : sc_q + SC_W'(1);
      if (halt_c) halted_d = 1'b1;
`ifdef CU_INTERRUPT_EN
      if ((sc_q >= T3) && ien_q && irq_i) r_d = 1'b1;
      if (ion_c)      ien_d = 1'b1;
      else if (iof_c) ien_d = 1'b0;
      if (rt_done_c) begin
        ien_d = 1'b0;
        r_d   = 1'b0;
      end
`endif
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sc_q     <= '0;
      halted_q <= 1'b0;
`ifdef CU_INTERRUPT_EN
      ien_q    <= 1'b0;
      r_q      <= 1'b0;
`endif
    end else begin
      sc_q     <= sc_d;
      halted_q <= halted_d;
`ifdef CU_INTERRUPT_EN
      ien_q    <= ien_d;
      r_q      <= r_d;
`endif
    end
  end

  // Output gating: reset forces clr PC, halt silences everything, stalls hold strobes
  always_comb begin
    ld_o      = '0;
    inr_o     = '0;
    clr_o     = '0;
    mem_rd_o  = 1'b0;
    mem_wr_o  = 1'b0;
    bus_sel_o = BUS_NONE;
    alu_op_o  = ALU_AND;
    if (reset_i) begin
      clr_o[R_PC] = 1'b1;
    end else if (!halted_q) begin
      mem_rd_o  = rd_c;
      mem_wr_o  = wr_c;
      bus_sel_o = bus_c;
      alu_op_o  = alu_c;
      if (adv_c) begin
        ld_o  = ld_c;
        inr_o = inr_c;
        clr_o = clr_c;
      end
    end
  end

  assign sc_o     = sc_q;
  assign halted_o = halted_q;
`ifdef CU_INTERRUPT_EN
  assign ien_o    = ien_q;
`else
  assign ien_o    = 1'b0;
`endif

endmodule

// File: tb/tb_hardwired_control_seq.sv
// Bench for hardwired_control_seq: per-instruction micro-step lists drive a
// scoreboard of expected control words, checked by a negedge monitor.
module tb_hardwired_control_seq;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned SC_W   = 4;
`ifdef CU_INTERRUPT_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  localparam logic [4:0] L_AR = 5'b10000, L_PC = 5'b01000, L_DR = 5'b00100,
                         L_AC = 5'b00010, L_IR = 5'b00001;
  localparam logic [3:0] R_AR = 4'b1000, R_PC = 4'b0100, R_DR = 4'b0010, R_AC = 4'b0001;
  localparam logic [2:0] B_NONE = 3'd0, B_AR = 3'd1, B_PC = 3'd2, B_DR = 3'd3,
                         B_AC = 3'd4, B_IR = 3'd5, B_MEM = 3'd7;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [DATA_W-1:0] ir = '0;
  logic              mem_ready = 1'b1;
  logic              dr_zero = 1'b0;
  logic              irq = 1'b0;
  logic [4:0]        ld;
  logic [3:0]        inr, clr;
  logic              mem_rd, mem_wr;
  logic [2:0]        bus_sel;
  logic [1:0]        alu_op;
  logic [SC_W-1:0]   sc;
  logic              halted, ien;

  hardwired_control_seq #(.DATA_W(DATA_W), .SC_W(SC_W)) dut (
    .clk_i(clk), .reset_i(reset), .ir_i(ir), .mem_ready_i(mem_ready),
    .dr_zero_i(dr_zero), .irq_i(irq), .ld_o(ld), .inr_o(inr), .clr_o(clr),
    .mem_rd_o(mem_rd), .mem_wr_o(mem_wr), .bus_sel_o(bus_sel), .alu_op_o(alu_op),
    .sc_o(sc), .halted_o(halted), .ien_o(ien)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]      ld;
    logic [3:0]      inr;
    logic [3:0]      clr;
    logic            rd;
    logic            wr;
    logic [2:0]      bus;
    logic [1:0]      alu;
    logic [SC_W-1:0] sc;
    logic            halted;
    logic            ien;
  } obs_t;

  typedef struct {
    obs_t  val;
    obs_t  care;
    string tag;
  } exp_t;

  typedef struct {
    logic [4:0] ld;
    logic [3:0] inr;
    logic [3:0] clr;
    bit         rd;
    bit         wr;
    logic [2:0] bus;
    logic [1:0] alu;
    bit         isz;
    bit         halt;
    bit         ion;
    bit         iof;
    bit         rt_end;
  } uop_t;

  exp_t sb[$];
  uop_t prog[$];
  int   checks = 0;
  int   failures = 0;

  // Reference architectural state
  bit m_halted = 1'b0;
  bit m_ien = 1'b0;
  bit m_r = 1'b0;

  int wait_mode = 0;    // <0 random wait states on memory steps
  int dz_mode = -1;     // <0 random dr_zero
  int irq_mode = 0;     // 0 low, 1 high, else random
  int halt_cycles = 3;

  function automatic string fmt(obs_t o);
    return $sformatf("ld=%b inr=%b clr=%b rd=%b wr=%b bus=%0d alu=%0d sc=%0d halted=%b ien=%b",
                     o.ld, o.inr, o.clr, o.rd, o.wr, o.bus, o.alu, o.sc, o.halted, o.ien);
  endfunction

  // Monitor: every cycle the DUT presents a control word; compare it to the next expectation
  always @(negedge clk) begin
    exp_t e;
    obs_t a;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      a.ld = ld; a.inr = inr; a.clr = clr; a.rd = mem_rd; a.wr = mem_wr;
      a.bus = bus_sel; a.alu = alu_op; a.sc = sc; a.halted = halted; a.ien = ien;
      checks++;
      if (((a ^ e.val) & e.care) != '0) begin
        failures++;
        $display("FAIL %s: got {%s} expected {%s}", e.tag, fmt(a & e.care), fmt(e.val & e.care));
      end
    end
  end

  function automatic uop_t mk(logic [4:0] l, logic [3:0] in, logic [3:0] cl,
                              bit r, bit w, logic [2:0] b, logic [1:0] al);
    uop_t u;
    u = '{default: 0};
    u.ld = l; u.inr = in; u.clr = cl; u.rd = r; u.wr = w; u.bus = b; u.alu = al;
    return u;
  endfunction

  // Micro-step list of one instruction, fetch included; list index = timing step
  task automatic build_instr(input logic [DATA_W-1:0] v);
    logic       i_b;
    logic [2:0] d;
    uop_t       u;
    i_b = v[DATA_W-1];
    d   = v[DATA_W-2 -: 3];
    prog.delete();
    prog.push_back(mk(L_AR, 4'b0, 4'b0, 0, 0, B_PC, 2'd0));
    prog.push_back(mk(L_IR, R_PC, 4'b0, 1, 0, B_MEM, 2'd0));
    prog.push_back(mk(L_AR, 4'b0, 4'b0, 0, 0, B_IR, 2'd0));
    if (d == 3'd7) begin
      u = mk(5'b0, 4'b0, 4'b0, 0, 0, B_NONE, 2'd0);
      if (!i_b) begin
        if (v[5])  u.inr = R_AC;
        if (v[11]) u.clr = R_AC;
        u.ion = v[7]; u.iof = v[6]; u.halt = v[0];
      end
      prog.push_back(u);
      return;
    end
    if (i_b) prog.push_back(mk(L_AR, 4'b0, 4'b0, 1, 0, B_MEM, 2'd0));
    else     prog.push_back(mk(5'b0, 4'b0, 4'b0, 0, 0, B_NONE, 2'd0));
    case (d)
      3'd0, 3'd1, 3'd2: begin
        prog.push_back(mk(L_DR, 4'b0, 4'b0, 1, 0, B_MEM, 2'd0));
        prog.push_back(mk(L_AC, 4'b0, 4'b0, 0, 0, B_NONE, d[1:0]));
      end
      3'd3: prog.push_back(mk(5'b0, 4'b0, 4'b0, 0, 1, B_AC, 2'd0));
      3'd4: prog.push_back(mk(L_PC, 4'b0, 4'b0, 0, 0, B_AR, 2'd0));
      3'd5: begin
        prog.push_back(mk(5'b0, R_AR, 4'b0, 0, 1, B_PC, 2'd0));
        prog.push_back(mk(L_PC, 4'b0, 4'b0, 0, 0, B_AR, 2'd0));
      end
      default: begin
        prog.push_back(mk(L_DR, 4'b0, 4'b0, 1, 0, B_MEM, 2'd0));
        prog.push_back(mk(5'b0, R_DR, 4'b0, 0, 0, B_NONE, 2'd0));
        u = mk(5'b0, 4'b0, 4'b0, 0, 1, B_DR, 2'd0);
        u.isz = 1'b1;
        prog.push_back(u);
      end
    endcase
  endtask

  task automatic build_rt();
    uop_t u;
    prog.delete();
    prog.push_back(mk(5'b0, 4'b0, R_AR, 0, 0, B_NONE, 2'd0));
    prog.push_back(mk(5'b0, 4'b0, R_PC, 0, 1, B_PC, 2'd0));
    u = mk(5'b0, R_PC, 4'b0, 0, 0, B_NONE, 2'd0);
    u.rt_end = 1'b1;
    prog.push_back(u);
  endtask

  function automatic exp_t step_exp(uop_t u, int n, bit done, bit dz, string tag);
    exp_t e;
    e.val = '0;
    e.care = '1;
    e.tag = tag;
    e.val.rd = u.rd; e.val.wr = u.wr; e.val.bus = u.bus; e.val.alu = u.alu;
    e.val.sc = SC_W'(n);
    e.val.halted = 1'b0;
    e.val.ien = m_ien;
    if (done) begin
      e.val.ld  = u.ld;
      e.val.inr = u.inr | ((u.isz && dz) ? R_PC : 4'b0);
      e.val.clr = u.clr;
    end
    return e;
  endfunction

  function automatic bit pick_irq();
    if (irq_mode == 0) return 1'b0;
    if (irq_mode == 1) return 1'b1;
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic bit pick_dz();
    if (dz_mode < 0) return 1'($urandom_range(0, 1));
    return dz_mode != 0;
  endfunction

  task automatic cyc(input bit rst, input bit rdy, input bit dz, input bit iq, input exp_t e);
    reset = rst; mem_ready = rdy; dr_zero = dz; irq = iq;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic reset_cycle(input string tag);
    exp_t e;
    e.val = '0;
    e.val.clr = R_PC;
    e.care = '0;
    e.care.ld = '1; e.care.inr = '1; e.care.clr = '1; e.care.rd = 1'b1; e.care.wr = 1'b1;
    e.tag = tag;
    cyc(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), e);
    m_halted = 1'b0; m_ien = 1'b0; m_r = 1'b0;
  endtask

  task automatic run_seq(input string kind);
    for (int n = 0; n < prog.size(); n++) begin
      uop_t u;
      bit   mem, dz, iq, rdy;
      int   w;
      u   = prog[n];
      mem = u.rd || u.wr;
      w   = !mem ? 0 : (wait_mode >= 0 ? wait_mode : int'($urandom_range(0, 3)));
      for (int k = 0; k < w; k++)
        cyc(1'b0, 1'b0, 1'($urandom_range(0, 1)), pick_irq(),
            step_exp(u, n, 1'b0, 1'b0, $sformatf("%s T%0d stall", kind, n)));
      dz  = pick_dz();
      iq  = pick_irq();
      rdy = mem ? 1'b1 : 1'($urandom_range(0, 1));
      cyc(1'b0, rdy, dz, iq, step_exp(u, n, 1'b1, dz, $sformatf("%s T%0d", kind, n)));
      if (IRQ_EN && n >= 3 && m_ien && iq) m_r = 1'b1;
      if (IRQ_EN && u.ion) m_ien = 1'b1;
      else if (IRQ_EN && u.iof) m_ien = 1'b0;
      if (u.rt_end) begin m_ien = 1'b0; m_r = 1'b0; end
      if (u.halt) m_halted = 1'b1;
    end
  endtask

  task automatic run_instr(input logic [DATA_W-1:0] v);
    exp_t e;
    ir = v;
    if (m_r) begin
      build_rt();
      run_seq("RT");
    end
    build_instr(v);
    run_seq($sformatf("ir=%h", v));
    if (m_halted) begin
      for (int k = 0; k < halt_cycles; k++) begin
        e.val = '0; e.val.halted = 1'b1; e.val.ien = m_ien;
        e.care = '1;
        e.tag = $sformatf("halted cyc%0d", k);
        cyc(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), e);
      end
      reset_cycle("reset after halt");
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DATA_W-1:0] r;
    @(posedge clk);
    #1;
    reset_cycle("reset");

    // LDA direct, no wait states
    wait_mode = 0; irq_mode = 0;
    run_instr(16'h2010);
    // Fetch and operand read each held off for 3 cycles
    wait_mode = 3;
    run_instr(16'h2010);
    // ISZ with and without zero result
    wait_mode = 0;
    dz_mode = 1; run_instr(16'h6005);
    dz_mode = 0; run_instr(16'h6005);
    dz_mode = -1;
    // HLT held for 10 cycles, then reset and resume
    halt_cycles = 10;
    run_instr(16'h7001);
    run_instr(16'h1123);
    halt_cycles = 3;

    // Reset in the middle of a fetch stall
    ir = 16'h2010;
    build_instr(16'h2010);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, step_exp(prog[0], 0, 1'b1, 1'b0, "midstall T0"));
    cyc(1'b0, 1'b0, 1'b0, 1'b0, step_exp(prog[1], 1, 1'b0, 1'b0, "midstall T1 stall"));
    cyc(1'b0, 1'b0, 1'b0, 1'b0, step_exp(prog[1], 1, 1'b0, 1'b0, "midstall T1 stall"));
    reset_cycle("reset during stall");
    run_instr(16'h3044);

    // ION then steady irq: interrupt cycle at the following boundary
    irq_mode = 1;
    run_instr(16'h7080);
    run_instr(16'h2010);
    run_instr(16'h4020);
    run_instr(16'h0010);
    irq_mode = 0;
    run_instr(16'h7040);

    // Random instruction mix with random waits, dr_zero and irq
    wait_mode = -1; irq_mode = 2;
    for (int k = 0; k < 200; k++) begin
      r = DATA_W'($urandom);
      if (r[DATA_W-2 -: 3] == 3'd7 && !r[DATA_W-1]) begin
        r[0] = ($urandom_range(0, 15) == 0);
        if (r[7] && r[6]) r[6] = 1'b0;
      end
      run_instr(r);
    end

    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expectations required 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
